// File: rtl/rpn_pkg.sv
// rpn_pkg: shared stack opcodes, token/error encodings and FSM state names
// for the RPN sequencer and its testbench.
package rpn_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    typedef enum logic [1:0] {
        TK_OPND = 2'b00,
        TK_ADD  = 2'b01,
        TK_MUL  = 2'b10,
        TK_END  = 2'b11
    } tok_kind_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_UNDER = 2'b01,
        ERR_FULL  = 2'b10,
        ERR_END   = 2'b11
    } err_code_e;

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_POP     = 3'd1,
        S_CAPT    = 3'd2,
        S_DONE    = 3'd3,
        S_FLUSH   = 3'd4,
        S_DISCARD = 3'd5
    } state_e;

endpackage

// File: rtl/rpn_sequencer_if.sv
// rpn_sequencer_if: token stream, stack command/status and result channels.
// master is the sequencer side; slave is the token source, stack and result consumer.
interface rpn_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             tok_valid;
    logic             tok_ready;
    logic [1:0]       tok_kind;
    logic [WIDTH-1:0] tok_value;
    logic [2:0]       stk_opcode;
    logic [WIDTH-1:0] stk_data;
    logic [WIDTH-1:0] stk_out;
    logic             stk_full;
    logic             stk_empty;
    logic             stk_overflow;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_ovf;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        input  tok_valid, tok_kind, tok_value,
        input  stk_out, stk_full, stk_empty, stk_overflow,
        input  res_ready,
        output tok_ready, stk_opcode, stk_data,
        output res_valid, res_data, res_ovf, err, err_code
    );

    modport slave (
        output tok_valid, tok_kind, tok_value,
        output stk_out, stk_full, stk_empty, stk_overflow,
        output res_ready,
        input  tok_ready, stk_opcode, stk_data,
        input  res_valid, res_data, res_ovf, err, err_code
    );
endinterface

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: turns an RPN token stream into one-cycle stack commands and returns each result.
// Build macro RPN_SEQ_STATS_EN adds saturating 16-bit expr_cnt/err_cnt outputs.
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    rpn_sequencer_if.master bus
`ifdef RPN_SEQ_STATS_EN
    ,
    output logic [15:0]     expr_cnt,
    output logic [15:0]     err_cnt
`endif
);

    localparam int            DW        = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    localparam logic [2:0] ST_RUN     = S_RUN;
    localparam logic [2:0] ST_POP     = S_POP;
    localparam logic [2:0] ST_CAPT    = S_CAPT;
    localparam logic [2:0] ST_DONE    = S_DONE;
    localparam logic [2:0] ST_FLUSH   = S_FLUSH;
    localparam logic [2:0] ST_DISCARD = S_DISCARD;

    logic [2:0]       state;
    logic [DW-1:0]    depth;
    logic [2:0]       opcode_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_ovf_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic             end_err_q;

    tok_kind_e  kind;
    logic [2:0] run_op;
    err_code_e  run_err;
    logic       tok_ready;
    logic       err_hit;
    logic       ovf_window;

    // Decide what the current token would do against the tracked depth.
    always_comb begin
        kind    = tok_kind_e'(bus.tok_kind);
        run_op  = OP_NOP;
        run_err = ERR_NONE;
        case (kind)
            TK_OPND: if (depth == DEPTH_MAX) run_err = ERR_FULL;  else run_op = OP_PUSH;
            TK_ADD:  if (depth < DW'(2))     run_err = ERR_UNDER; else run_op = OP_ADD;
            TK_MUL:  if (depth < DW'(2))     run_err = ERR_UNDER; else run_op = OP_MUL;
            default: if (depth != DW'(1))    run_err = ERR_END;   else run_op = OP_POP;
        endcase
    end

    assign tok_ready  = (state == ST_RUN) || (state == ST_DISCARD);
    assign err_hit    = (state == ST_RUN) && bus.tok_valid && (run_err != ERR_NONE);
    assign ovf_window = (state == ST_RUN) || (state == ST_POP) || (state == ST_CAPT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            depth      <= '0;
            opcode_q   <= OP_NOP;
            data_q     <= '0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            end_err_q  <= 1'b0;
        end else begin
            opcode_q <= OP_NOP;
            if (ovf_window && bus.stk_overflow) res_ovf_q <= 1'b1;
            case (state)
                ST_RUN: begin
                    if (err_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= run_err;
                        end_err_q  <= (kind == TK_END);
                        // A rejected end token already closed the expression, so nothing to discard.
                        if (depth != '0)        state <= ST_FLUSH;
                        else if (kind != TK_END) state <= ST_DISCARD;
                    end else if (bus.tok_valid) begin
                        opcode_q <= run_op;
                        case (kind)
                            TK_OPND: begin
                                data_q <= bus.tok_value;
                                depth  <= depth + DW'(1);
                            end
                            TK_END: begin
                                depth <= '0;
                                state <= ST_POP;
                            end
                            default: depth <= depth - DW'(1);
                        endcase
                    end
                end
                ST_POP:  state <= ST_CAPT;
                ST_CAPT: begin
                    res_data_q <= bus.stk_out;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        res_ovf_q  <= 1'b0;
                        err_q      <= 1'b0;
                        err_code_q <= ERR_NONE;
                        state      <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    opcode_q <= OP_POP;
                    depth    <= depth - DW'(1);
                    if (depth == DW'(1)) state <= end_err_q ? ST_RUN : ST_DISCARD;
                end
                ST_DISCARD: begin
                    if (bus.tok_valid && kind == TK_END) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.tok_ready  = tok_ready;
    assign bus.stk_opcode = opcode_q;
    assign bus.stk_data   = data_q;
    assign bus.res_valid  = (state == ST_DONE);
    assign bus.res_data   = res_data_q;
    assign bus.res_ovf    = res_ovf_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;

`ifdef RPN_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            expr_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (state == ST_DONE && bus.res_ready && expr_cnt != 16'hFFFF)
                expr_cnt <= expr_cnt + 16'd1;
            if (err_hit && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/rpn_sequencer.md
# rpn_sequencer

Upstream driver for the stack ALU. Accepts a stream of postfix (RPN) tokens over a valid/ready handshake and converts each token into a one-cycle stack command (push/add/mul/pop). It returns the final value of each expression with an overflow flag. It tracks stack depth itself, rejects malformed expressions before they reach the stack, and flushes the stack after an error so the next expression starts clean.

## Interface
- DEPTH, 256, stack capacity; must match the downstream stack.
- WIDTH, 4, data width; must match the downstream stack.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset; the top level drives the stack's reset from the same source.
- tok_valid  in  1  token present.
- tok_ready  out  1  sequencer accepts a token this cycle.
- tok_kind  in  2  00 operand, 01 add, 10 mul, 11 end-of-expression.
- tok_value  in  WIDTH  operand value; ignored unless tok_kind=00.
- stk_opcode  out  3  stack command: 000 nop, 100 add, 101 mul, 110 push, 111 pop.
- stk_data  out  WIDTH  push data.
- stk_out  in  WIDTH  stack output_data.
- stk_full, stk_empty, stk_overflow  in  1 each  stack status flags.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  WIDTH  expression result.
- res_ovf  out  1  an add or mul in this expression overflowed WIDTH.
- err  out  1  the last expression was rejected.
- err_code  out  2  00 none, 01 underflow, 10 push at full, 11 bad end.

## Operation
- **States:** RUN, POP, CAPT, DONE, FLUSH, DISCARD.
- **Depth counter:** $clog2(DEPTH+1) bits, range 0..DEPTH.
- **RUN:** tok_ready=1. Each handshake registers exactly one command for one cycle; stk_opcode is 000 at all other times.
  - Operand: error 10 if depth==DEPTH; otherwise push, depth+1.
  - Add/mul: error 01 if depth<2; otherwise issue the op, depth-1.
  - End: error 11 if depth!=1; otherwise issue a pop, depth→0, go to POP.
- **Normal result path:**
  - POP → CAPT: wait for the stack to execute the pop.
  - CAPT: latch stk_out into res_data, go to DONE.
  - DONE: res_valid=1, held stable until res_ready. On handshake: clear res_ovf, err and err_code, return to RUN.
- **res_ovf:** sticky. Set by stk_overflow sampled in any cycle from RUN through CAPT of the current expression.
- **On error:**
  - The offending token is consumed but no command is issued.
  - err=1, err_code set; both hold until the next successful result handshake.
  - Go to FLUSH if depth>0, else DISCARD.
- **FLUSH:** tok_ready=0. Issue one pop per cycle and decrement depth. When depth reaches 0, go to DISCARD; if the offending token was an end token, go to RUN instead.
- **DISCARD:** tok_ready=1. Drop tokens with no commands issued until an end token is accepted, then go to RUN.
- **Arithmetic:** add and mul are modulo 2^WIDTH inside the stack. The sequencer does no arithmetic beyond the depth counter.

## Timing
- **Reset values:** state RUN, depth 0, stk_opcode 000, stk_data 0, res_valid 0, res_data 0, res_ovf 0, err 0, err_code 00. tok_ready=1 in the first cycle after rst deasserts.
- **Command latency:** token accepted in cycle N → stk_opcode/stk_data driven in N+1 → stack executes on the edge ending N+1.
- **Result latency:** end token accepted in N → pop driven in N+1 → stk_out valid in N+2 → res_valid=1 in N+3.
- **Throughput:** one token per cycle in RUN. tok_ready=0 in POP, CAPT, DONE and FLUSH.
- **Flush duration:** exactly depth cycles, one pop each.
- **Reset mid-operation:** rst wins in any state. The sequencer and stack return to reset values together, and any in-flight result is lost.

## Configuration
- **RPN_SEQ_STATS_EN defined:** adds outputs expr_cnt and err_cnt, 16 bits each, reset to 0, saturating.
  - expr_cnt increments on each result handshake.
  - err_cnt increments on each error detection.
- **RPN_SEQ_STATS_EN undefined:** the ports and counters are absent; all other behaviour is identical.

## Structure
- **Package rpn_pkg:**
  - Stack opcode constants: OP_NOP, OP_ADD, OP_MUL, OP_PUSH, OP_POP.
  - tok_kind_e, err_code_e and state_e enums.
- **rpn_sequencer:** a single module with no sub-module. The stack is instantiated beside it at the top level, not inside it.

## Test plan
- **Add:** WIDTH=4; tokens 5, 2, add, end → stk_opcode 110, 110, 100, 111 on consecutive cycles; res_data=7, res_ovf=0, res_valid 3 cycles after the end token.
- **Add overflow:** tokens F, 1, add, end → res_data=0, res_ovf=1; on the next expression 3, 4, mul, end → res_data=C, res_ovf=0.
- **Mul overflow and backpressure:** tokens F, 2, mul, end with res_ready held low 5 cycles → res_valid and res_data=E, res_ovf=1 held stable until res_ready.
- **Underflow recovery:** tokens 5, add → err_code=01, one flush pop, tok_ready=0 for 1 cycle. Then tokens 9, end are discarded; next 1, 1, add, end → res_data=2, err cleared.
- **Push at full:** DEPTH+1 operands → err_code=10 on token 257; 256 flush pops follow; stk_empty=1 afterwards.
- **Reset mid-expression:** rst asserted after 3 pushes → all outputs at reset values the next cycle, stack empty; tokens 2, 3, mul, end → res_data=6.
